// File: rtl/input_debouncer.sv
// input_debouncer: two-flop synchronizer plus stability counter producing a clean level and rise/fall pulses
module input_debouncer #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W = $clog2(STABLE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic din_raw,
  output logic level,
  output logic rise,
  output logic fall,
  output logic busy
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
  logic s1, s2, accept;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  // accept once the differing sample has been seen STABLE_CYCLES times in a row
  always_comb begin
    accept  = (s2 != level) && (cnt == LAST);
    cnt_nxt = (s2 == level || accept) ? '0 : cnt + 1'b1;
  end
  // synchronizer, counter, debounced level and edge pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      s1    <= din_raw;
      s2    <= s1;
      cnt   <= cnt_nxt;
      level <= accept ? s2 : level;
      rise  <= accept & s2;
      fall  <= accept & ~s2;
      busy  <= cnt_nxt != '0;
    end
  end
endmodule

// File: tb/tb_input_debouncer.sv
// tb_input_debouncer: randomized and directed checks of two debouncer instances against a sample-history model
module tb_input_debouncer;
  logic clk = 1'b0;
  logic rst, din_raw;
  logic level4, rise4, fall4, busy4;
  logic level1, rise1, fall1, busy1;
  int tests = 0;
  int fails = 0;
  int n = -1;
  logic din_at [0:8191];
  logic rst_at [0:8191];
  logic lvl [2];
  int   last_ev [2];
  logic e_rise [2];
  logic e_fall [2];
  logic e_busy [2];

  always #5 clk = ~clk;

  input_debouncer #(.STABLE_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst), .din_raw(din_raw),
    .level(level4), .rise(rise4), .fall(fall4), .busy(busy4)
  );

  input_debouncer #(.STABLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .din_raw(din_raw),
    .level(level1), .rise(rise1), .fall(fall1), .busy(busy1)
  );

  // value the debouncer compares at edge m: din_raw two edges earlier, zero if a reset intervened
  function automatic logic sync_at(input int m);
    if (m < 2) return 1'b0;
    if (rst_at[m-1] || rst_at[m-2]) return 1'b0;
    return din_at[m-2];
  endfunction

  // level flips when the last N synchronized samples since the last event all differ from it
  task automatic upd(input int i, input int stable);
    int r;
    logic acc;
    e_rise[i] = 1'b0;
    e_fall[i] = 1'b0;
    e_busy[i] = 1'b0;
    if (rst_at[n]) begin
      lvl[i] = 1'b0;
      last_ev[i] = n;
      return;
    end
    r = 0;
    for (int j = 0; j < stable; j++) begin
      if (n - j <= last_ev[i]) break;
      if (sync_at(n - j) == lvl[i]) break;
      r++;
    end
    acc = (r == stable);
    if (acc) begin
      e_rise[i] = sync_at(n);
      e_fall[i] = ~sync_at(n);
      lvl[i] = sync_at(n);
      last_ev[i] = n;
    end
    e_busy[i] = (r > 0) && !acc;
  endtask

  task automatic chk(input string tag, input logic got, input logic exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s edge=%0d got=%b expected=%b", tag, n, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    n++;
    din_at[n] = din_raw;
    rst_at[n] = rst;
    upd(0, 4);
    upd(1, 1);
    #1;
    chk("level4", level4, lvl[0]);
    chk("rise4", rise4, e_rise[0]);
    chk("fall4", fall4, e_fall[0]);
    chk("busy4", busy4, e_busy[0]);
    chk("level1", level1, lvl[1]);
    chk("rise1", rise1, e_rise[1]);
    chk("fall1", fall1, e_fall[1]);
    chk("busy1", busy1, e_busy[1]);
  endtask

  task automatic drive(input logic v, input int cycles);
    din_raw = v;
    for (int c = 0; c < cycles; c++) step();
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      lvl[i] = 1'b0;
      last_ev[i] = -1;
    end
    rst = 1'b1;
    din_raw = 1'b1;
    step();
    step();
    chk("rst_level", level4, 1'b0);
    chk("rst_busy", busy4, 1'b0);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) step();
    chk("rel_level_early", level4, 1'b0);
    step();
    chk("rel_level_6th", level4, 1'b1);
    chk("rel_rise_6th", rise4, 1'b1);
    step();
    chk("rel_rise_off", rise4, 1'b0);
    drive(1'b0, 10);
    chk("clean_fall_level", level4, 1'b0);
    drive(1'b1, 10);
    drive(1'b0, 10);
    drive(1'b1, 3);
    drive(1'b0, 10);
    chk("glitch_level", level4, 1'b0);
    chk("glitch_busy", busy4, 1'b0);
    for (int b = 0; b < 5; b++) drive(b[0] ? 1'b0 : 1'b1, 1);
    drive(1'b1, 10);
    chk("bounce_level", level4, 1'b1);
    drive(1'b0, 10);
    din_raw = 1'b1;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    chk("midrst_busy", busy4, 1'b0);
    rst = 1'b0;
    drive(1'b1, 10);
    chk("midrst_level", level4, 1'b1);
    drive(1'b0, 10);
    for (int it = 0; it < 400; it++) begin
      rst = ($urandom_range(0, 40) == 0);
      din_raw = 1'($urandom_range(0, 1));
      step();
      rst = 1'b0;
      for (int c = $urandom_range(0, 7); c > 0; c--) step();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
